// File: rtl/mem_arb.sv
// ============================================================================
// Module   : mem_arb
// Purpose  : Arbiter and sequencer for the single shared memory port. It picks
//            one of two requesters (instruction fetch, data load/store),
//            latches its command, holds the memory busy for WAIT+1 cycles and
//            returns read data with a one-cycle acknowledge.
// Ports    : clk, rst_f              clock, synchronous active-high reset
//            if_req/if_addr/if_ack   fetch requester handshake
//            d_req/d_we/d_addr/
//            d_wdata/d_ack           data requester handshake
//            rdata                   last captured read data
//            mem_en/mem_we/mem_addr/
//            mem_wdata/mem_rdata     synchronous SRAM port
//            busy, owner             status (owner: 0 = fetch, 1 = data)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb #(
  parameter int AW   = 16,
  parameter int DW   = 32,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_done   = 2'd2;

  localparam logic [3:0] c_wait_cnt  = 4'(WAIT);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;   // doubles as the last-grantee record
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          w_grant;            // some request is present in IDLE
  logic          w_grant_data;       // 1 = data wins, 0 = fetch wins
  logic          w_last_cycle;       // final ACCESS cycle

  // Arbitration: on a tie, the requester that did not win last time goes.
  always_comb begin
    w_grant      = (state_q == c_st_idle) && (if_req || d_req);
    w_grant_data = 1'b0;
    if (if_req && d_req) begin
      w_grant_data = ~owner_q;
    end else begin
      w_grant_data = d_req;
    end
    w_last_cycle = (state_q == c_st_access) && (cnt_q == c_wait_cnt);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q <= c_st_idle;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:   if (w_grant) state_d = c_st_access;
      c_st_access: if (w_last_cycle) state_d = c_st_done;
      c_st_done:   state_d = c_st_idle;
      default:     state_d = c_st_idle;
    endcase
  end

  // Command latch, wait counter and read-data capture
  always_comb begin
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (w_grant) begin
      cnt_d   = 4'd0;
      owner_d = w_grant_data;
      if (w_grant_data) begin
        we_d    = d_we;
        addr_d  = d_addr;
        wdata_d = d_wdata;
      end else begin
        we_d    = 1'b0;
        addr_d  = if_addr;
        wdata_d = '0;
      end
    end else if (state_q == c_st_access) begin
      cnt_d = cnt_q + 4'd1;
      if (w_last_cycle && !we_q) begin
        rdata_d = mem_rdata;
      end
    end
  end

  // Outputs decoded from state and latched command only
  always_comb begin
    mem_en = (state_q == c_st_access);
    mem_we = (state_q == c_st_access) && we_q;
    busy   = (state_q != c_st_idle);
    if_ack = (state_q == c_st_done) && !owner_q;
    d_ack  = (state_q == c_st_done) && owner_q;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign owner     = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// ============================================================================
// Module   : tb_mem_arb
// Purpose  : Directed self-checking bench for mem_arb. Two instances are
//            exercised: one built with WAIT=1, one with WAIT=0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WAIT = 1 instance
  logic        rst_f, if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, busy, owner;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, rdata;

  // WAIT = 0 instance
  logic        rst0, if_req0, d_req0, d_we0;
  logic [15:0] if_addr0, d_addr0;
  logic [31:0] d_wdata0, mem_rdata0;
  logic        if_ack0, d_ack0, mem_en0, mem_we0, busy0, owner0;
  logic [15:0] mem_addr0;
  logic [31:0] mem_wdata0, rdata0;

  mem_arb #(.AW(16), .DW(32), .WAIT(1)) u_dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arb #(.AW(16), .DW(32), .WAIT(0)) u_dut0 (
    .clk(clk), .rst_f(rst0),
    .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0), .d_ack(d_ack0),
    .rdata(rdata0), .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0), .owner(owner0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset with both requests high ----------------
    rst_f = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 16'h0010; d_addr = 16'h0030; d_wdata = 32'h0; mem_rdata = 32'h1111_1111;
    rst0 = 1'b1; if_req0 = 1'b0; d_req0 = 1'b0; d_we0 = 1'b0;
    if_addr0 = 16'h0; d_addr0 = 16'h0; d_wdata0 = 32'h0; mem_rdata0 = 32'h0;
    tick; tick;
    chk("rst_mem_en",    {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks",      {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_owner",     {31'd0, owner}, 32'd0);
    chk("rst_rdata",     rdata, 32'd0);

    // ---------------- first tie goes to data; d_req dropped in ACCESS ----
    rst_f = 1'b0;
    tick;
    chk("tie_owner",     {31'd0, owner}, 32'd1);
    chk("tie_busy",      {31'd0, busy}, 32'd1);
    chk("tie_mem_en",    {31'd0, mem_en}, 32'd1);
    chk("tie_mem_addr",  {16'd0, mem_addr}, 32'h0030);
    d_req = 1'b0; if_req = 1'b0;
    tick;
    chk("drop_acc2_en",  {31'd0, mem_en}, 32'd1);
    chk("drop_acc2_ack", {31'd0, d_ack}, 32'd0);
    tick;
    chk("drop_d_ack",    {31'd0, d_ack}, 32'd1);
    chk("drop_if_ack",   {31'd0, if_ack}, 32'd0);
    chk("drop_rdata",    rdata, 32'h1111_1111);
    chk("drop_done_en",  {31'd0, mem_en}, 32'd0);
    tick;
    chk("drop_idle_ack", {31'd0, d_ack}, 32'd0);
    chk("drop_idle_busy",{31'd0, busy}, 32'd0);
    tick;
    chk("drop_no_regrant", {31'd0, busy}, 32'd0);

    // ---------------- single fetch, WAIT=1 ----------------
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 32'hDEAD_BEEF;
    tick;
    chk("f_acc1_en",     {31'd0, mem_en}, 32'd1);
    chk("f_acc1_addr",   {16'd0, mem_addr}, 32'h0010);
    chk("f_acc1_we",     {31'd0, mem_we}, 32'd0);
    chk("f_owner",       {31'd0, owner}, 32'd0);
    tick;
    chk("f_acc2_en",     {31'd0, mem_en}, 32'd1);
    chk("f_acc2_addr",   {16'd0, mem_addr}, 32'h0010);
    chk("f_acc2_ack",    {31'd0, if_ack}, 32'd0);
    tick;
    chk("f_if_ack",      {31'd0, if_ack}, 32'd1);
    chk("f_d_ack",       {31'd0, d_ack}, 32'd0);
    chk("f_rdata",       rdata, 32'hDEAD_BEEF);
    chk("f_done_en",     {31'd0, mem_en}, 32'd0);
    if_req = 1'b0;
    tick;
    chk("f_idle_ack",    {31'd0, if_ack}, 32'd0);
    chk("f_idle_busy",   {31'd0, busy}, 32'd0);

    // ---------------- store ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'h1234_5678;
    mem_rdata = 32'h5555_5555;
    tick;
    chk("s_acc1_we",     {31'd0, mem_we}, 32'd1);
    chk("s_acc1_addr",   {16'd0, mem_addr}, 32'h0020);
    chk("s_acc1_wdata",  mem_wdata, 32'h1234_5678);
    chk("s_owner",       {31'd0, owner}, 32'd1);
    tick;
    chk("s_acc2_we",     {31'd0, mem_we}, 32'd1);
    tick;
    chk("s_d_ack",       {31'd0, d_ack}, 32'd1);
    chk("s_rdata_kept",  rdata, 32'hDEAD_BEEF);
    chk("s_done_we",     {31'd0, mem_we}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick;
    chk("s_idle_ack",    {31'd0, d_ack}, 32'd0);

    // ---------------- both held: alternation (last grantee was data) ----
    if_req = 1'b1; d_req = 1'b1; d_addr = 16'h0040; if_addr = 16'h0050;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("alt_owner",   {31'd0, owner}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("alt_addr",    {16'd0, mem_addr}, (k % 2 == 0) ? 32'h0050 : 32'h0040);
      tick;
      chk("alt_acc2_busy", {31'd0, busy}, 32'd1);
      tick;
      chk("alt_if_ack",  {31'd0, if_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_d_ack",   {31'd0, d_ack},  (k % 2 == 0) ? 32'd0 : 32'd1);
      tick;
      chk("alt_idle",    {31'd0, busy}, 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick;
    chk("alt_end_idle",  {31'd0, busy}, 32'd0);

    // ---------------- WAIT=0 instance ----------------
    rst0 = 1'b0;
    tick;
    chk("w0_rst_rdata",  rdata0, 32'd0);
    chk("w0_rst_busy",   {31'd0, busy0}, 32'd0);
    if_req0 = 1'b1; if_addr0 = 16'h0044; mem_rdata0 = 32'hA5A5_A5A5;
    tick;
    chk("w0_acc_en",     {31'd0, mem_en0}, 32'd1);
    chk("w0_acc_addr",   {16'd0, mem_addr0}, 32'h0044);
    tick;
    chk("w0_if_ack",     {31'd0, if_ack0}, 32'd1);
    chk("w0_done_en",    {31'd0, mem_en0}, 32'd0);
    chk("w0_rdata",      rdata0, 32'hA5A5_A5A5);
    if_req0 = 1'b0;
    tick;
    chk("w0_idle_ack",   {31'd0, if_ack0}, 32'd0);

    // reset during ACCESS aborts the access
    d_req0 = 1'b1; d_addr0 = 16'h0066;
    tick;
    chk("w0_abort_acc",  {31'd0, mem_en0}, 32'd1);
    rst0 = 1'b1; d_req0 = 1'b0;
    tick;
    chk("w0_abort_en",   {31'd0, mem_en0}, 32'd0);
    chk("w0_abort_ack",  {31'd0, d_ack0}, 32'd0);
    chk("w0_abort_busy", {31'd0, busy0}, 32'd0);
    chk("w0_abort_addr", {16'd0, mem_addr0}, 32'd0);
    rst0 = 1'b0;
    tick;
    chk("w0_post_ack",   {31'd0, d_ack0}, 32'd0);
    chk("w0_post_busy",  {31'd0, busy0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
